// File: rtl/vproc_unit_dispatch.sv
// Dispatches operands to one of NUM_UNITS execution units and returns results in dispatch order.
// Latency: dispatch is combinational (0 cycles); result to out_* is 1 cycle, one result per cycle.
// Backpressure: in_ready_o drops when the order FIFO is full or the target unit stalls; a stalled output blocks unit results.
//
// Ports:
//   clk_i, sync_rst_i                   clock, synchronous active-high reset
//   in_valid_i/in_ready_o, in_unit_i,   dispatch handshake, target unit, operands and byte mask
//   in_op1_i, in_op2_i, in_mask_i
//   unit_valid_o/unit_ready_i,          per-unit issue handshake; operands broadcast to all units
//   unit_op1_o, unit_op2_o, unit_mask_o
//   unit_res_valid_i/unit_res_ready_o,  per-unit result handshake; slice k belongs to unit k
//   unit_res_i, unit_res_mask_i
//   out_valid_o/out_ready_i, out_res_o, merged in-order result, its mask and source unit
//   out_mask_o, out_unit_o
//   pending_cnt_o, busy_o, err_o        in-flight count, activity flag, sticky illegal-unit flag
module vproc_unit_dispatch #(
  parameter int OPERAND_WIDTH  = 64,
  parameter int NUM_UNITS      = 5,
  parameter int ORDER_DEPTH    = 8,
  parameter int DONT_CARE_ZERO = 0,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int CW = $clog2(ORDER_DEPTH + 1),
  localparam int MW = OPERAND_WIDTH / 8
) (
  input  logic                           clk_i,
  input  logic                           sync_rst_i,

  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [UW-1:0]                  in_unit_i,
  input  logic [OPERAND_WIDTH-1:0]       in_op1_i,
  input  logic [OPERAND_WIDTH-1:0]       in_op2_i,
  input  logic [MW-1:0]                  in_mask_i,

  output logic [NUM_UNITS-1:0]           unit_valid_o,
  input  logic [NUM_UNITS-1:0]           unit_ready_i,
  output logic [OPERAND_WIDTH-1:0]       unit_op1_o,
  output logic [OPERAND_WIDTH-1:0]       unit_op2_o,
  output logic [MW-1:0]                  unit_mask_o,

  input  logic [NUM_UNITS-1:0]           unit_res_valid_i,
  output logic [NUM_UNITS-1:0]           unit_res_ready_o,
  input  logic [NUM_UNITS*OPERAND_WIDTH-1:0] unit_res_i,
  input  logic [NUM_UNITS*MW-1:0]        unit_res_mask_i,

  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [OPERAND_WIDTH-1:0]       out_res_o,
  output logic [MW-1:0]                  out_mask_o,
  output logic [UW-1:0]                  out_unit_o,

  output logic [CW-1:0]                  pending_cnt_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int PW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam logic [UW:0]   NUM_UNITS_W = (UW + 1)'(NUM_UNITS);
  localparam logic [CW-1:0] DEPTH_CNT   = CW'(ORDER_DEPTH);

  // Order FIFO: records the target unit of every accepted dispatch.
  logic [UW-1:0] order_mem [ORDER_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  // Output register.
  logic                     out_valid_q;
  logic [OPERAND_WIDTH-1:0] res_q;
  logic [MW-1:0]            mask_q;
  logic [UW-1:0]            unit_q;
  logic                     err_q;

  logic                     legal;
  logic                     not_full;
  logic                     empty;
  logic                     out_adv;
  logic [UW-1:0]            head;
  logic                     sel_rdy;
  logic                     head_vld;
  logic [OPERAND_WIDTH-1:0] head_res;
  logic [MW-1:0]            head_mask;
  logic                     push;
  logic                     pop;

  always_comb begin
    legal    = ({1'b0, in_unit_i} < NUM_UNITS_W);
    // Fullness is judged on the registered count only, so a same-cycle pop
    // never frees a slot for a same-cycle dispatch.
    not_full = (cnt != DEPTH_CNT);
    // Treat the FIFO as empty while reset is asserted so no unit result is
    // acknowledged from ordering state that is about to be discarded.
    empty    = (cnt == '0) | sync_rst_i;
    out_adv  = !out_valid_q | out_ready_i;
    head     = order_mem[rd_ptr];

    sel_rdy          = 1'b0;
    head_vld         = 1'b0;
    head_res         = '0;
    head_mask        = '0;
    unit_valid_o     = '0;
    unit_res_ready_o = '0;

    for (int k = 0; k < NUM_UNITS; k++) begin
      if (in_unit_i == UW'(k)) begin
        sel_rdy         = unit_ready_i[k];
        unit_valid_o[k] = in_valid_i & not_full;
      end
      if (head == UW'(k)) begin
        head_vld            = unit_res_valid_i[k];
        head_res            = unit_res_i[k*OPERAND_WIDTH +: OPERAND_WIDTH];
        head_mask           = unit_res_mask_i[k*MW +: MW];
        unit_res_ready_o[k] = !empty & out_adv;
      end
    end

    // An illegal index is swallowed: accepted but never issued or tracked.
    in_ready_o = legal ? (sel_rdy & not_full) : 1'b1;
    push       = in_valid_i & legal & sel_rdy & not_full;
    pop        = !empty & out_adv & head_vld;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      order_mem[wr_ptr] <= in_unit_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      mask_q      <= '0;
      unit_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (!push && pop) begin
        cnt <= cnt - 1'b1;
      end

      if (pop) begin
        out_valid_q <= 1'b1;
        res_q       <= head_res;
        mask_q      <= head_mask;
        unit_q      <= head;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      if (in_valid_i && !legal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign unit_op1_o    = in_op1_i;
  assign unit_op2_o    = in_op2_i;
  assign unit_mask_o   = in_mask_i;

  assign out_valid_o   = out_valid_q;
  assign out_res_o     = ((DONT_CARE_ZERO != 0) && !out_valid_q) ? '0 : res_q;
  assign out_mask_o    = ((DONT_CARE_ZERO != 0) && !out_valid_q) ? '0 : mask_q;
  assign out_unit_o    = ((DONT_CARE_ZERO != 0) && !out_valid_q) ? '0 : unit_q;

  assign pending_cnt_o = cnt;
  assign busy_o        = (cnt != '0) | out_valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_vproc_unit_dispatch.sv
// Directed checks of in-order dispatch/retire: reset, ordering, full FIFO,
// output backpressure, illegal unit index, throughput and mid-operation reset.
module tb_vproc_unit_dispatch;

  localparam int W  = 64;
  localparam int NU = 5;
  localparam int UW = 3;
  localparam int CW = 4;
  localparam int MW = W / 8;

  logic             clk_i = 1'b0;
  logic             sync_rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [UW-1:0]    in_unit_i;
  logic [W-1:0]     in_op1_i, in_op2_i;
  logic [MW-1:0]    in_mask_i;
  logic [NU-1:0]    unit_valid_o;
  logic [NU-1:0]    unit_ready_i;
  logic [W-1:0]     unit_op1_o, unit_op2_o;
  logic [MW-1:0]    unit_mask_o;
  logic [NU-1:0]    unit_res_valid_i;
  logic [NU-1:0]    unit_res_ready_o;
  logic [NU*W-1:0]  unit_res_i;
  logic [NU*MW-1:0] unit_res_mask_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [W-1:0]     out_res_o;
  logic [MW-1:0]    out_mask_o;
  logic [UW-1:0]    out_unit_o;
  logic [CW-1:0]    pending_cnt_o;
  logic             busy_o;
  logic             err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  vproc_unit_dispatch #(
    .OPERAND_WIDTH (W),
    .NUM_UNITS     (NU),
    .ORDER_DEPTH   (8),
    .DONT_CARE_ZERO(0)
  ) dut (
    .clk_i           (clk_i),
    .sync_rst_i      (sync_rst_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_unit_i       (in_unit_i),
    .in_op1_i        (in_op1_i),
    .in_op2_i        (in_op2_i),
    .in_mask_i       (in_mask_i),
    .unit_valid_o    (unit_valid_o),
    .unit_ready_i    (unit_ready_i),
    .unit_op1_o      (unit_op1_o),
    .unit_op2_o      (unit_op2_o),
    .unit_mask_o     (unit_mask_o),
    .unit_res_valid_i(unit_res_valid_i),
    .unit_res_ready_o(unit_res_ready_o),
    .unit_res_i      (unit_res_i),
    .unit_res_mask_i (unit_res_mask_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_res_o       (out_res_o),
    .out_mask_o      (out_mask_o),
    .out_unit_o      (out_unit_o),
    .pending_cnt_o   (pending_cnt_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_res(input int k, input logic [W-1:0] v);
    unit_res_i[k*W +: W]       = v;
    unit_res_mask_i[k*MW +: MW] = v[MW-1:0];
  endtask

  initial begin
    sync_rst_i       = 1'b1;
    in_valid_i       = 1'b0;
    in_unit_i        = '0;
    in_op1_i         = '0;
    in_op2_i         = '0;
    in_mask_i        = '0;
    unit_ready_i     = '1;
    unit_res_valid_i = '0;
    unit_res_i       = '0;
    unit_res_mask_i  = '0;
    out_ready_i      = 1'b1;

    // Reset
    cycle();
    cycle();
    sync_rst_i = 1'b0;
    #1;
    check_eq("rst_pending", 64'(pending_cnt_o), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid_o), 64'd0);
    check_eq("rst_err", 64'(err_o), 64'd0);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_res_ready", 64'(unit_res_ready_o), 64'd0);

    // Ordering: A -> unit 2, B -> unit 0; unit 0 finishes first but must wait.
    in_valid_i = 1'b1;
    in_unit_i  = 3'd2;
    in_op1_i   = 64'hAAAA_0001;
    in_op2_i   = 64'hAAAA_0002;
    in_mask_i  = 8'h0F;
    #1;
    check_eq("ord_c0_valid", 64'(unit_valid_o), 64'b00100);
    check_eq("ord_c0_ready", 64'(in_ready_o), 64'd1);
    check_eq("ord_c0_op1", unit_op1_o, 64'hAAAA_0001);
    check_eq("ord_c0_op2", unit_op2_o, 64'hAAAA_0002);
    check_eq("ord_c0_mask", 64'(unit_mask_o), 64'h0F);
    cycle();
    in_unit_i = 3'd0;
    in_op1_i  = 64'hBBBB_0001;
    #1;
    check_eq("ord_c1_valid", 64'(unit_valid_o), 64'b00001);
    check_eq("ord_c1_pending", 64'(pending_cnt_o), 64'd1);
    cycle();
    in_valid_i = 1'b0;
    unit_res_valid_i[0] = 1'b1;
    set_res(0, 64'h0000_BBBB);
    for (int c = 2; c <= 5; c++) begin
      if (c == 5) begin
        unit_res_valid_i[2] = 1'b1;
        set_res(2, 64'h0000_AAAA);
      end
      #1;
      check_eq($sformatf("ord_c%0d_rdy0", c), 64'(unit_res_ready_o[0]), 64'd0);
      check_eq($sformatf("ord_c%0d_outv", c), 64'(out_valid_o), 64'd0);
      check_eq($sformatf("ord_c%0d_pend", c), 64'(pending_cnt_o), 64'd2);
      cycle();
    end
    unit_res_valid_i[2] = 1'b0;
    #1;
    check_eq("ord_c6_outv", 64'(out_valid_o), 64'd1);
    check_eq("ord_c6_res", out_res_o, 64'h0000_AAAA);
    check_eq("ord_c6_unit", 64'(out_unit_o), 64'd2);
    check_eq("ord_c6_rdy", 64'(unit_res_ready_o), 64'b00001);
    check_eq("ord_c6_pend", 64'(pending_cnt_o), 64'd1);
    cycle();
    unit_res_valid_i = '0;
    #1;
    check_eq("ord_c7_outv", 64'(out_valid_o), 64'd1);
    check_eq("ord_c7_res", out_res_o, 64'h0000_BBBB);
    check_eq("ord_c7_mask", 64'(out_mask_o), 64'hBB);
    check_eq("ord_c7_unit", 64'(out_unit_o), 64'd0);
    check_eq("ord_c7_busy", 64'(busy_o), 64'd1);
    cycle();
    #1;
    check_eq("ord_c8_outv", 64'(out_valid_o), 64'd0);
    check_eq("ord_c8_busy", 64'(busy_o), 64'd0);

    // Full: eight dispatches, no results. Units 0,1,2,3,4,0,1,2.
    for (int i = 0; i < 8; i++) begin
      in_valid_i = 1'b1;
      in_unit_i  = UW'(i % NU);
      #1;
      check_eq($sformatf("full_rdy%0d", i), 64'(in_ready_o), 64'd1);
      cycle();
    end
    in_unit_i = 3'd1;
    #1;
    check_eq("full_pending", 64'(pending_cnt_o), 64'd8);
    check_eq("full_in_ready", 64'(in_ready_o), 64'd0);
    check_eq("full_unit_valid", 64'(unit_valid_o), 64'd0);
    for (int k = 0; k < NU; k++) set_res(k, 64'hF0 + 64'(k));
    unit_res_valid_i[0] = 1'b1;
    #1;
    check_eq("full_pop_blocks", 64'(in_ready_o), 64'd0);
    check_eq("full_pop_rdy", 64'(unit_res_ready_o), 64'b00001);
    cycle();
    #1;
    check_eq("full_after_pop_rdy", 64'(in_ready_o), 64'd1);
    check_eq("full_after_pop_pend", 64'(pending_cnt_o), 64'd7);
    check_eq("full_after_pop_unit", 64'(out_unit_o), 64'd0);
    in_valid_i       = 1'b0;
    unit_res_valid_i = '1;
    begin
      int exp_u [7] = '{1, 2, 3, 4, 0, 1, 2};
      for (int j = 0; j < 7; j++) begin
        cycle();
        #1;
        check_eq($sformatf("drain%0d_outv", j), 64'(out_valid_o), 64'd1);
        check_eq($sformatf("drain%0d_unit", j), 64'(out_unit_o), 64'(exp_u[j]));
        check_eq($sformatf("drain%0d_res", j), out_res_o, 64'hF0 + 64'(exp_u[j]));
      end
    end
    check_eq("drain_pending", 64'(pending_cnt_o), 64'd0);
    unit_res_valid_i = '0;
    cycle();

    // Backpressure: output held while out_ready_i is low.
    in_valid_i = 1'b1;
    in_unit_i  = 3'd3;
    cycle();
    cycle();
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    unit_res_valid_i[3] = 1'b1;
    set_res(3, 64'h1111_2222_3333_4444);
    cycle();
    set_res(3, 64'h5555_6666_7777_8888);
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq($sformatf("bp%0d_outv", c), 64'(out_valid_o), 64'd1);
      check_eq($sformatf("bp%0d_res", c), out_res_o, 64'h1111_2222_3333_4444);
      check_eq($sformatf("bp%0d_rdy", c), 64'(unit_res_ready_o), 64'd0);
      check_eq($sformatf("bp%0d_pend", c), 64'(pending_cnt_o), 64'd1);
      cycle();
    end
    out_ready_i = 1'b1;
    #1;
    check_eq("bp_release_rdy", 64'(unit_res_ready_o), 64'b01000);
    cycle();
    unit_res_valid_i = '0;
    #1;
    check_eq("bp_second_res", out_res_o, 64'h5555_6666_7777_8888);
    check_eq("bp_second_pend", 64'(pending_cnt_o), 64'd0);
    cycle();
    #1;
    check_eq("bp_idle_outv", 64'(out_valid_o), 64'd0);
    check_eq("bp_hold_res", out_res_o, 64'h5555_6666_7777_8888);

    // Throughput: unit 1 dispatched and completing every cycle.
    unit_res_valid_i[1] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid_i = (i < 6);
      in_unit_i  = 3'd1;
      set_res(1, 64'd100 + 64'(i));
      #1;
      if (i >= 2 && i <= 7) begin
        check_eq($sformatf("tp%0d_outv", i), 64'(out_valid_o), 64'd1);
        check_eq($sformatf("tp%0d_res", i), out_res_o, 64'd100 + 64'(i - 1));
      end
      if (i >= 1 && i <= 6) begin
        check_eq($sformatf("tp%0d_pend", i), 64'(pending_cnt_o), 64'd1);
      end
      if (i == 8) begin
        check_eq("tp_end_outv", 64'(out_valid_o), 64'd0);
      end
      cycle();
    end
    unit_res_valid_i = '0;
    in_valid_i       = 1'b0;

    // Illegal unit index.
    in_valid_i = 1'b1;
    in_unit_i  = 3'd6;
    #1;
    check_eq("ill_in_ready", 64'(in_ready_o), 64'd1);
    check_eq("ill_unit_valid", 64'(unit_valid_o), 64'd0);
    check_eq("ill_err_now", 64'(err_o), 64'd0);
    cycle();
    in_valid_i = 1'b0;
    #1;
    check_eq("ill_err_next", 64'(err_o), 64'd1);
    check_eq("ill_pending", 64'(pending_cnt_o), 64'd0);
    cycle();
    cycle();
    #1;
    check_eq("ill_err_sticky", 64'(err_o), 64'd1);

    // Reset with operations in flight.
    in_valid_i = 1'b1;
    in_unit_i  = 3'd4;
    cycle();
    cycle();
    cycle();
    in_valid_i = 1'b0;
    #1;
    check_eq("mrst_pre_pend", 64'(pending_cnt_o), 64'd3);
    sync_rst_i = 1'b1;
    unit_res_valid_i[4] = 1'b1;
    #1;
    check_eq("mrst_res_ready", 64'(unit_res_ready_o), 64'd0);
    cycle();
    cycle();
    sync_rst_i = 1'b0;
    unit_res_valid_i = '0;
    #1;
    check_eq("mrst_pending", 64'(pending_cnt_o), 64'd0);
    check_eq("mrst_out_valid", 64'(out_valid_o), 64'd0);
    check_eq("mrst_err", 64'(err_o), 64'd0);
    check_eq("mrst_busy", 64'(busy_o), 64'd0);
    check_eq("mrst_out_res", out_res_o, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
